// File: rtl/vga_scan_controller_if.sv
// Bundle of the scan controller's CPU snapshot handshake and renderer-facing
// outputs. The controller drives the "master" side; the CPU/renderer side
// (or a testbench standing in for them) uses the "slave" side.
interface vga_scan_controller_if;
    // CPU -> controller
    logic         snap_ack;
    logic [175:0] registers_in;
    logic [15:0]  pc_in;
    logic [15:0]  ir_in;
    // controller -> renderer / CPU
    logic [10:0]  x;
    logic [10:0]  y;
    logic         hsync;
    logic         vsync;
    logic         active;
    logic         snap_req;
    logic [175:0] registers_out;
    logic [15:0]  pc_out;
    logic [15:0]  ir_out;
    logic [3:0]   missed;

    modport master (
        input  snap_ack, registers_in, pc_in, ir_in,
        output x, y, hsync, vsync, active, snap_req,
               registers_out, pc_out, ir_out, missed
    );

    modport slave (
        output snap_ack, registers_in, pc_in, ir_in,
        input  x, y, hsync, vsync, active, snap_req,
               registers_out, pc_out, ir_out, missed
    );
endinterface

// File: rtl/vga_scan_controller.sv
// VGA scan generator for the debug display: pixel-tick divider, h/v counters,
// registered sync/active decode, and a once-per-frame CPU state snapshot that
// is requested when vertical blanking begins and abandoned at frame wrap.
module vga_scan_controller #(
    parameter int PIX_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic                  clk,
    input  logic                  rst,
    vga_scan_controller_if.master bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(PIX_DIV - 1);
    localparam logic [10:0]      H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0]      V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0]      V_ACT_LAST = 11'(V_ACTIVE - 1);
    localparam logic [10:0]      H_ACT      = 11'(H_ACTIVE);
    localparam logic [10:0]      V_ACT      = 11'(V_ACTIVE);
    localparam logic [10:0]      HS_BEG     = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0]      HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0]      VS_BEG     = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0]      VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } snap_state_t;

    // Half-open interval test used for the sync pulse windows.
    function automatic logic in_window(input logic [10:0] v,
                                       input logic [10:0] lo,
                                       input logic [10:0] hi);
        return (v >= lo) && (v < hi);
    endfunction

    // Saturating increment for the missed-snapshot counter.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? 4'hF : (v + 4'd1);
    endfunction

    logic [DIV_W-1:0] r_div;
    logic [10:0]      r_x;
    logic [10:0]      r_y;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_active;
    snap_state_t      r_state;
    logic             r_snap_req;
    logic [175:0]     r_regs;
    logic [15:0]      r_pc;
    logic [15:0]      r_ir;
    logic [3:0]       r_missed;

    logic             w_tick;
    logic             w_line_end;
    logic             w_frame_end;
    logic             w_blank_start;
    logic [10:0]      w_x_nxt;
    logic [10:0]      w_y_nxt;

    // Pixel tick, line/frame boundary events and next-state counter values.
    always_comb begin
        w_tick        = (r_div == DIV_LAST);
        w_line_end    = w_tick && (r_x == H_LAST);
        w_frame_end   = w_line_end && (r_y == V_LAST);
        w_blank_start = w_line_end && (r_y == V_ACT_LAST);
        w_x_nxt       = r_x;
        w_y_nxt       = r_y;
        if (w_line_end) begin
            w_x_nxt = 11'd0;
            if (r_y == V_LAST) begin
                w_y_nxt = 11'd0;
            end else begin
                w_y_nxt = r_y + 11'd1;
            end
        end else if (w_tick) begin
            w_x_nxt = r_x + 11'd1;
        end else begin
            w_x_nxt = r_x;
        end
    end

    // Divider, counters and sync/active decoded from next-state counters so
    // the registered strobes line up with the x/y presented alongside them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div    <= {DIV_W{1'b0}};
            r_x      <= 11'd0;
            r_y      <= 11'd0;
            r_hsync  <= 1'b1;
            r_vsync  <= 1'b1;
            r_active <= 1'b1;
        end else begin
            r_div    <= w_tick ? {DIV_W{1'b0}} : (r_div + DIV_W'(1));
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_hsync  <= ~in_window(w_x_nxt, HS_BEG, HS_END);
            r_vsync  <= ~in_window(w_y_nxt, VS_BEG, VS_END);
            r_active <= (w_x_nxt < H_ACT) && (w_y_nxt < V_ACT);
        end
    end

    // Snapshot handshake: request at blanking start, latch on ack, count a
    // miss if the frame wraps first. An ack on the wrap edge takes priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_snap_req <= 1'b0;
            r_regs     <= 176'd0;
            r_pc       <= 16'd0;
            r_ir       <= 16'd0;
            r_missed   <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_blank_start) begin
                        r_state    <= ST_REQ;
                        r_snap_req <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (bus.snap_ack) begin
                        r_regs     <= bus.registers_in;
                        r_pc       <= bus.pc_in;
                        r_ir       <= bus.ir_in;
                        r_state    <= ST_DONE;
                        r_snap_req <= 1'b0;
                    end else if (w_frame_end) begin
                        r_state    <= ST_IDLE;
                        r_snap_req <= 1'b0;
                        r_missed   <= sat_inc4(r_missed);
                    end
                end
                ST_DONE: begin
                    if (w_frame_end) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_snap_req <= 1'b0;
                end
            endcase
        end
    end

    assign bus.x             = r_x;
    assign bus.y             = r_y;
    assign bus.hsync         = r_hsync;
    assign bus.vsync         = r_vsync;
    assign bus.active        = r_active;
    assign bus.snap_req      = r_snap_req;
    assign bus.registers_out = r_regs;
    assign bus.pc_out        = r_pc;
    assign bus.ir_out        = r_ir;
    assign bus.missed        = r_missed;

endmodule
